// File: rtl/priority_enc_4_2_equation.sv
// 4:2 priority encoder built from sum-of-products equations, with valid and
// contention flags and an optional output register stage.
module priority_enc_4_2_equation #(
    parameter int OUT_REG      = 1,
    parameter int MSB_PRIORITY = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_code,
    output logic [1:0] o_code,
    output logic       o_valid,
    output logic       o_multi
);

    logic [1:0] code_d;
    logic       valid_d;
    logic       multi_d;

    logic c0, c1, c2, c3;
    assign c0 = i_code[0];
    assign c1 = i_code[1];
    assign c2 = i_code[2];
    assign c3 = i_code[3];

    // Each equation is written so that an all-zero request vector yields 00.
    generate
        if (MSB_PRIORITY != 0) begin : g_msb_first
            assign code_d[1] = c3 | c2;
            assign code_d[0] = c3 | (~c2 & c1);
        end else begin : g_lsb_first
            assign code_d[1] = (~c0 & ~c1 & c2) | (~c0 & ~c1 & c3);
            assign code_d[0] = (~c0 & c1) | (~c0 & ~c2 & c3);
        end
    endgenerate

    assign valid_d = c0 | c1 | c2 | c3;

    // Any pair of set bits means at least two requests are competing.
    assign multi_d = (c0 & c1) | (c0 & c2) | (c0 & c3)
                   | (c1 & c2) | (c1 & c3) | (c2 & c3);

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [1:0] code_q;
            logic       valid_q;
            logic       multi_q;

            // All three outputs share one register stage so none can lag.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    code_q  <= 2'b00;
                    valid_q <= 1'b0;
                    multi_q <= 1'b0;
                end else begin
                    code_q  <= code_d;
                    valid_q <= valid_d;
                    multi_q <= multi_d;
                end
            end

            assign o_code  = code_q;
            assign o_valid = valid_q;
            assign o_multi = multi_q;
        end else begin : g_comb
            assign o_code  = code_d;
            assign o_valid = valid_d;
            assign o_multi = multi_d;
        end
    endgenerate

endmodule

// File: tb/tb_priority_enc_4_2_equation.sv
// Bench for priority_enc_4_2_equation: registered MSB-first (defaults),
// registered LSB-first and combinational MSB-first instances.
module tb_priority_enc_4_2_equation;

    logic       clk;
    logic       rst;
    logic [3:0] code;

    logic [1:0] m_code, l_code, c_code;
    logic       m_valid, l_valid, c_valid;
    logic       m_multi, l_multi, c_multi;

    int tests;
    int fails;

    priority_enc_4_2_equation u_msb (
        .i_clk(clk), .i_rst(rst), .i_code(code),
        .o_code(m_code), .o_valid(m_valid), .o_multi(m_multi)
    );

    priority_enc_4_2_equation #(.OUT_REG(1), .MSB_PRIORITY(0)) u_lsb (
        .i_clk(clk), .i_rst(rst), .i_code(code),
        .o_code(l_code), .o_valid(l_valid), .o_multi(l_multi)
    );

    priority_enc_4_2_equation #(.OUT_REG(0), .MSB_PRIORITY(1)) u_comb (
        .i_clk(clk), .i_rst(rst), .i_code(code),
        .o_code(c_code), .o_valid(c_valid), .o_multi(c_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        logic [3:0] exp_msb;   // {o_code, o_valid, o_multi}
        logic [3:0] exp_lsb;
    } vec_t;

    vec_t tbl[9];

    // Reference: scan request bits in priority order, count set bits.
    function automatic logic [3:0] model(input logic [3:0] c, input bit msb_first);
        int idx;
        int cnt;
        idx = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) cnt++;
        end
        if (msb_first) begin
            for (int i = 0; i < 4; i++) if (c[i]) idx = i;
        end else begin
            for (int i = 3; i >= 0; i--) if (c[i]) idx = i;
        end
        model = {2'(idx), (cnt > 0), (cnt >= 2)};
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (code/valid/multi)", name, act, exp);
        end
    endtask

    logic [3:0] prev;

    initial begin
        tests = 0;
        fails = 0;

        tbl[0] = '{4'b0000, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0001, 4'b0010, 4'b0010};
        tbl[2] = '{4'b0100, 4'b1010, 4'b1010};
        tbl[3] = '{4'b0101, 4'b1011, 4'b0011};
        tbl[4] = '{4'b1111, 4'b1111, 4'b0011};
        tbl[5] = '{4'b1100, 4'b1111, 4'b1011};
        tbl[6] = '{4'b1000, 4'b1110, 4'b1110};
        tbl[7] = '{4'b1010, 4'b1111, 4'b0111};
        tbl[8] = '{4'b0110, 4'b1011, 4'b0111};

        // Reset held several cycles with all requests asserted.
        rst  = 1'b1;
        code = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_hold_msb", {m_code, m_valid, m_multi}, 4'b0000);
            chk("reset_hold_lsb", {l_code, l_valid, l_multi}, 4'b0000);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("reset_release_msb", {m_code, m_valid, m_multi}, 4'b1111);
        chk("reset_release_lsb", {l_code, l_valid, l_multi}, 4'b0011);

        // Table vectors, one per cycle, checked one cycle later.
        for (int i = 0; i < 9; i++) begin
            code = tbl[i].code;
            #1;
            chk("tbl_comb", {c_code, c_valid, c_multi}, tbl[i].exp_msb);
            @(negedge clk);
            chk("tbl_msb", {m_code, m_valid, m_multi}, tbl[i].exp_msb);
            chk("tbl_lsb", {l_code, l_valid, l_multi}, tbl[i].exp_lsb);
        end

        // Exhaustive sweep with wrap, back-to-back vectors.
        prev = code;
        for (int i = 0; i < 18; i++) begin
            code = 4'(i);
            @(negedge clk);
            chk("sweep_msb", {m_code, m_valid, m_multi}, model(4'(i), 1'b1));
            chk("sweep_lsb", {l_code, l_valid, l_multi}, model(4'(i), 1'b0));
        end

        // Mid-stream reset discards the vector sampled at the reset edge.
        code = 4'b0101;
        @(negedge clk);
        rst  = 1'b1;
        code = 4'b1000;
        @(negedge clk);
        chk("midrst_msb", {m_code, m_valid, m_multi}, 4'b0000);
        chk("midrst_lsb", {l_code, l_valid, l_multi}, 4'b0000);
        rst  = 1'b0;
        code = 4'b0010;
        @(negedge clk);
        chk("midrst_after_msb", {m_code, m_valid, m_multi}, 4'b0110);
        chk("midrst_after_lsb", {l_code, l_valid, l_multi}, 4'b0110);

        // Combinational instance follows input between clock edges.
        @(posedge clk);
        #2 code = 4'b0011;
        #1 chk("comb_mid_cycle_a", {c_code, c_valid, c_multi}, 4'b0111);
        code = 4'b0000;
        #1 chk("comb_mid_cycle_b", {c_code, c_valid, c_multi}, 4'b0000);
        rst = 1'b1;
        code = 4'b1001;
        #1 chk("comb_ignores_rst", {c_code, c_valid, c_multi}, 4'b1111);
        @(negedge clk);
        rst = 1'b0;

        // Randomized back-to-back traffic against the reference model.
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            prev = 4'($urandom_range(0, 15));
            code = prev;
            #1;
            chk("rand_comb", {c_code, c_valid, c_multi}, model(prev, 1'b1));
            @(negedge clk);
            chk("rand_msb", {m_code, m_valid, m_multi}, model(prev, 1'b1));
            chk("rand_lsb", {l_code, l_valid, l_multi}, model(prev, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/priority_enc_4_2_equation.md
PRIORITY_ENC_4_2_EQUATION -- requirements
Module: priority_enc_4_2_equation

Interface
REQ-001 Parameter OUT_REG, default 1: 1 = outputs registered (one-cycle latency); 0 = outputs combinational from i_code.
REQ-002 Parameter MSB_PRIORITY, default 1: 1 = bit 3 highest priority; 0 = bit 0 highest priority.
REQ-003 i_clk  input  1  system clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_code  input  4  request vector, one bit per request line.
REQ-006 o_code  output  2  binary index of the winning (highest-priority set) request bit.
REQ-007 o_valid  output  1  high when at least one i_code bit is set.
REQ-008 o_multi  output  1  high when two or more i_code bits are set (contention indicator).
REQ-009 The block SHALL use one clock (i_clk) and a synchronous, active-high reset (i_rst); no other clocks, asynchronous resets or latches.

Function
REQ-010 Encoding, MSB_PRIORITY=1: i_code[3] set -> o_code=11; else [2] -> 10; else [1] -> 01; else [0] -> 00.
REQ-011 Encoding, MSB_PRIORITY=0: i_code[0] set -> 00; else [1] -> 01; else [2] -> 10; else [3] -> 11.
REQ-012 o_valid SHALL equal the OR of all four i_code bits.
REQ-013 i_code=0000: o_code SHALL be 00 and o_valid 0 (o_code is don't-care-free and fixed at 00).
REQ-014 o_multi SHALL be 1 iff the population count of i_code is >= 2.
REQ-015 Encoding logic SHALL be pure sum-of-products equations of i_code with no internal state other than the output registers.
REQ-016 OUT_REG=1: o_code, o_valid, o_multi SHALL reflect the i_code sampled on the previous rising i_clk edge (latency exactly 1 cycle, throughput one vector per cycle).
REQ-017 OUT_REG=0: outputs SHALL follow i_code combinationally with zero cycle latency; i_clk/i_rst have no effect on outputs.
REQ-018 All three outputs SHALL be updated together in the same cycle; no output SHALL lag another.
REQ-019 Lower-priority bits SHALL never affect o_code when a higher-priority bit is set (e.g. 1111, 1000, 1010 all give 11 with MSB_PRIORITY=1).

Reset
REQ-020 OUT_REG=1: with i_rst high at a rising i_clk edge, o_code SHALL become 00, o_valid 0, o_multi 0, regardless of i_code.
REQ-021 Reset held for N cycles SHALL hold outputs at reset values for those N cycles; first valid encoding appears one cycle after the first edge with i_rst low.
REQ-022 Reset asserted mid-stream SHALL discard the vector sampled at that edge; no stale result SHALL appear after reset release.
REQ-023 Outputs SHALL be defined (reset values) from the first reset edge; before any reset, output values are unspecified.

Verification
REQ-024 Exhaustive sweep, defaults: i_code 0000..1111 then wrap to 0000,0001 (18 vectors, one per cycle) -> o_code/o_valid match REQ-010/012 one cycle later; 0000 -> 00/0, 0001 -> 00/1, 0010..0011 -> 01/1, 0100..0111 -> 10/1, 1000..1111 -> 11/1.
REQ-025 Contention: i_code=1111 -> o_code=11, o_valid=1, o_multi=1; i_code=0100 -> 10,1,0; i_code=0101 -> 10,1,1.
REQ-026 MSB_PRIORITY=0: i_code=1111 -> o_code=00; 1100 -> 10; 1000 -> 11; 0000 -> 00, o_valid=0.
REQ-027 Reset: drive i_code=1111, assert i_rst one cycle -> outputs 00/0/0 at that edge; release -> 11/1/1 on next edge.
REQ-028 OUT_REG=0: change i_code between clock edges -> outputs change in same delta without waiting for i_clk.
